tt_sweep_ctrl: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/tt_settle_timer.sv | 35 +++
 rtl/tt_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam logic [15:0] DEFAULT_EXPECT_TT = 16'h3060;

    function automatic int tt_len(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each input vector is held.
module tt_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(SETTLE_CYC + 1);

    generate
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("tt_settle_timer: SETTLE_CYC must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Loaded with SETTLE_CYC; the final settle cycle is the one where cnt is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE_CYC);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == CW'(1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input vector of a gate, captures its truth table and compares it.
// Optional per-vector error counter enabled by defining TT_SWEEP_ERRCNT_EN.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int                        N_IN       = 4,
    parameter int                        SETTLE_CYC = 2,
    parameter logic [tt_len(N_IN)-1:0]   EXPECT_TT  = DEFAULT_EXPECT_TT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [N_IN-1:0]         gate_in,
    input  logic                    gate_out,
    output logic                    busy,
    output logic                    done,
    output logic [tt_len(N_IN)-1:0] tt_captured,
`ifdef TT_SWEEP_ERRCNT_EN
    output logic [N_IN:0]           err_cnt,
`endif
    output logic                    match
);

    localparam int TT_LEN = tt_len(N_IN);

    sweep_state_t        state;
    logic [N_IN:0]       idx;
    logic                last_vec;
    logic                accept;
    logic                timer_load;
    logic                timer_en;
    logic                expired;
    logic                match_next;
    logic [TT_LEN-1:0]   tt_sampled;

    assign last_vec   = (idx == (N_IN + 1)'(TT_LEN - 1));
    assign accept     = (state == IDLE) && start && !abort;
    assign timer_load = accept || ((state == SAMPLE) && !abort && !last_vec);
    assign timer_en   = (state == SETTLE);

    tt_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        tt_sampled = tt_captured;
        tt_sampled[idx[N_IN-1:0]] = gate_out;
    end

`ifdef TT_SWEEP_ERRCNT_EN
    logic          sample_err;
    logic [N_IN:0] err_next;

    assign sample_err = (gate_out != EXPECT_TT[idx[N_IN-1:0]]);
    assign err_next   = (sample_err && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    assign match_next = (tt_sampled == EXPECT_TT) && (err_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (state == SAMPLE && !abort) begin
            err_cnt <= err_next;
        end
    end
`else
    assign match_next = (tt_sampled == EXPECT_TT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            gate_in     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tt_captured <= '0;
            match       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SETTLE;
                        idx         <= '0;
                        gate_in     <= '0;
                        busy        <= 1'b1;
                        tt_captured <= '0;
                        match       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state   <= IDLE;
                        gate_in <= '0;
                        busy    <= 1'b0;
                        match   <= 1'b0;
                    end else if (expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // An abort here drops the sample taken in this cycle.
                    if (abort) begin
                        state   <= IDLE;
                        gate_in <= '0;
                        busy    <= 1'b0;
                        match   <= 1'b0;
                    end else begin
                        tt_captured <= tt_sampled;
                        if (last_vec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= match_next;
                        end else begin
                            state   <= SETTLE;
                            idx     <= idx + 1'b1;
                            gate_in <= gate_in + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    gate_in <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: default config plus a small N_IN=3 config.
module tb_tt_sweep_ctrl;

    localparam logic [15:0] A_EXP  = 16'h3060;
    localparam int          A_SC   = 2;
    localparam int          A_DONE = 16 * (A_SC + 1) + 1;
    localparam logic [7:0]  B_EXP  = 8'hA5;
    localparam int          B_SC   = 1;
    localparam int          B_DONE = 8 * (B_SC + 1) + 1;

    logic        clk;
    logic        rst_n;
    logic        start_a, abort_a, gate_out_a, busy_a, done_a, match_a;
    logic [3:0]  gate_in_a;
    logic [15:0] tt_a;
    logic [15:0] tt_model_a;
    logic        start_b, abort_b, gate_out_b, busy_b, done_b, match_b;
    logic [2:0]  gate_in_b;
    logic [7:0]  tt_b;
    logic [7:0]  tt_model_b;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [4:0]  err_cnt_a;
    logic [3:0]  err_cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    tt_sweep_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .gate_in(gate_in_a), .gate_out(gate_out_a), .busy(busy_a), .done(done_a),
        .tt_captured(tt_a),
`ifdef TT_SWEEP_ERRCNT_EN
        .err_cnt(err_cnt_a),
`endif
        .match(match_a)
    );

    tt_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(B_SC), .EXPECT_TT(B_EXP)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .gate_in(gate_in_b), .gate_out(gate_out_b), .busy(busy_b), .done(done_b),
        .tt_captured(tt_b),
`ifdef TT_SWEEP_ERRCNT_EN
        .err_cnt(err_cnt_b),
`endif
        .match(match_b)
    );

    // Behavioural gates: output is the model table indexed by the applied vector.
    assign gate_out_a = tt_model_a[gate_in_a];
    assign gate_out_b = tt_model_b[gate_in_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one A sweep from cycle 0 (start asserted now) through cycle 60.
    task automatic sweep_a(input int ab, input int r1, input int r2,
                           output int done_cnt, output int done_at,
                           output int gate_bad, output int idle_bad);
        int idle_from;
        idle_from = (ab >= 0) ? ab + 1 : A_DONE + 1;
        done_cnt = 0; done_at = -1; gate_bad = 0; idle_bad = 0;
        start_a = 1'b1; abort_a = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step();
            start_a = (c == r1) || (c == r2);
            abort_a = (c == ab);
            if (done_a === 1'b1) begin done_cnt++; done_at = c; end
            if (c < idle_from && c < A_DONE) begin
                if (busy_a !== 1'b1) gate_bad++;
                if ((c % (A_SC + 1)) == 0 && gate_in_a !== 4'((c / (A_SC + 1)) - 1)) gate_bad++;
            end else if (c >= idle_from) begin
                if (gate_in_a !== 4'd0 || busy_a !== 1'b0) idle_bad++;
            end
        end
        start_a = 1'b0; abort_a = 1'b0;
    endtask

    task automatic full_sweep_a(input string name, input logic [15:0] model);
        int dc, da, gb, ib, exp_err;
        tt_model_a = model;
        sweep_a(-1, -1, -1, dc, da, gb, ib);
        exp_err = $countones(model ^ A_EXP);
        if (exp_err > 31) exp_err = 31;
        checks++; if (dc !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, dc); end
        checks++; if (da !== A_DONE) begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, da, A_DONE); end
        checks++; if (gb !== 0) begin errors++; $display("FAIL %s gate_in_busy_seq: got %0d bad cycles expected 0", name, gb); end
        checks++; if (ib !== 0) begin errors++; $display("FAIL %s idle_after_done: got %0d bad cycles expected 0", name, ib); end
        checks++; if (tt_a !== model) begin errors++; $display("FAIL %s tt_captured: got %h expected %h", name, tt_a, model); end
        checks++; if (match_a !== (model == A_EXP)) begin errors++; $display("FAIL %s match: got %b expected %b", name, match_a, model == A_EXP); end
`ifdef TT_SWEEP_ERRCNT_EN
        checks++; if (err_cnt_a !== 5'(exp_err)) begin errors++; $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt_a, exp_err); end
`endif
    endtask

    task automatic full_sweep_b(input string name, input logic [7:0] model);
        int dc, da;
        dc = 0; da = -1;
        tt_model_b = model;
        start_b = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            start_b = 1'b0;
            if (done_b === 1'b1) begin dc++; da = c; end
        end
        checks++; if (dc !== 1 || da !== B_DONE) begin errors++; $display("FAIL %s done: got count %0d cycle %0d expected 1 at %0d", name, dc, da, B_DONE); end
        checks++; if (tt_b !== model) begin errors++; $display("FAIL %s tt_captured: got %h expected %h", name, tt_b, model); end
        checks++; if (match_b !== (model == B_EXP)) begin errors++; $display("FAIL %s match: got %b expected %b", name, match_b, model == B_EXP); end
`ifdef TT_SWEEP_ERRCNT_EN
        checks++; if (err_cnt_b !== 4'($countones(model ^ B_EXP))) begin errors++; $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt_b, $countones(model ^ B_EXP)); end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        tt_model_a = A_EXP; tt_model_b = B_EXP;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gate_in_a !== 4'd0) begin errors++; $display("FAIL reset gate_in_a: got %h expected 0", gate_in_a); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset busy_done_a: got %b%b expected 00", busy_a, done_a); end
        checks++; if (tt_a !== 16'h0) begin errors++; $display("FAIL reset tt_a: got %h expected 0", tt_a); end
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL reset match_a: got %b expected 0", match_a); end
        checks++; if (gate_in_b !== 3'd0 || tt_b !== 8'h0 || busy_b !== 1'b0 || done_b !== 1'b0 || match_b !== 1'b0) begin
            errors++; $display("FAIL reset dut_b: got gate_in %h tt %h busy %b done %b match %b expected all 0", gate_in_b, tt_b, busy_b, done_b, match_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_sweep();
        full_sweep_a("basic", A_EXP);
    endtask

    task automatic test_single_flip();
        logic [15:0] m;
        m = A_EXP;
        m[5] = ~m[5];
        full_sweep_a("flip_v5", m);
    endtask

    task automatic test_random_tables();
        for (int i = 0; i < 4; i++) full_sweep_a("random_a", 16'($urandom));
    endtask

    task automatic test_abort(input int ab);
        int dc, da, gb, ib, nsamp;
        logic [15:0] exp_tt;
        tt_model_a = A_EXP;
        sweep_a(ab, -1, -1, dc, da, gb, ib);
        nsamp = (ab - 1) / (A_SC + 1);
        if (nsamp > 16) nsamp = 16;
        exp_tt = A_EXP & 16'((32'd1 << nsamp) - 1);
        checks++; if (dc !== 0) begin errors++; $display("FAIL abort@%0d done_count: got %0d expected 0", ab, dc); end
        checks++; if (gb !== 0 || ib !== 0) begin errors++; $display("FAIL abort@%0d sequence: got %0d/%0d bad cycles expected 0/0", ab, gb, ib); end
        checks++; if (tt_a !== exp_tt) begin errors++; $display("FAIL abort@%0d tt_captured: got %h expected %h", ab, tt_a, exp_tt); end
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL abort@%0d match: got %b expected 0", ab, match_a); end
    endtask

    task automatic test_ignore_start();
        int dc, da, gb, ib, seen;
        tt_model_a = A_EXP;
        sweep_a(-1, 5, 30, dc, da, gb, ib);
        checks++; if (dc !== 1 || da !== A_DONE) begin errors++; $display("FAIL ignore_start done: got count %0d cycle %0d expected 1 at %0d", dc, da, A_DONE); end
        checks++; if (tt_a !== A_EXP || gb !== 0) begin errors++; $display("FAIL ignore_start result: got tt %h bad %0d expected %h bad 0", tt_a, gb, A_EXP); end
        // Restart after done must clear the previous table on acceptance.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if (tt_a !== 16'h0 || match_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL restart_clear: got tt %h match %b busy %b expected 0000 0 1", tt_a, match_a, busy_a);
        end
        seen = 0;
        for (int c = 2; c <= 60; c++) begin
            step();
            if (done_a === 1'b1) seen++;
        end
        checks++; if (seen !== 1 || tt_a !== A_EXP) begin errors++; $display("FAIL restart_sweep: got done count %0d tt %h expected 1 %h", seen, tt_a, A_EXP); end
    endtask

    task automatic test_async_reset();
        tt_model_a = 16'hFFFF;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (10) step();
        checks++; if (tt_a !== 16'h0007 || gate_in_a !== 4'd3) begin
            errors++; $display("FAIL pre_reset state: got tt %h gate_in %h expected 0007 3", tt_a, gate_in_a);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (gate_in_a !== 4'd0 || busy_a !== 1'b0 || tt_a !== 16'h0 || done_a !== 1'b0 || match_a !== 1'b0) begin
            errors++; $display("FAIL async_reset: got gate_in %h busy %b tt %h done %b match %b expected all 0", gate_in_a, busy_a, tt_a, done_a, match_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        full_sweep_a("post_reset", A_EXP);
    endtask

    task automatic test_small_config();
        full_sweep_b("small_exact", B_EXP);
        full_sweep_b("small_random", 8'($urandom));
        full_sweep_b("small_random", 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_single_flip();
        test_abort(20);
        test_abort($urandom_range(1, 48));
        test_ignore_start();
        test_async_reset();
        test_random_tables();
        test_small_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
